// File: rtl/playback_pkg.sv
// rtl/playback_pkg.sv - shared controller state type for playback_ctrl
// Purpose : holds the playback FSM state enum used by the top level.
// Ports   : none (package).
package playback_pkg;

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, debouncer and press-event pulse for one key
// Purpose : turns a raw active-low key into a one-cycle press event.
// Ports   : i_clk   - system clock
//           i_rst   - asynchronous active-high reset
//           i_key_n - raw active-low key, asynchronous to i_clk
//           o_press - one-cycle pulse on debounced 1->0 transition
module key_debounce #(
    parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CW = $clog2(32'(DEB_CYCLES) + 32'd1);
    localparam logic [CW-1:0] C_LAST = CW'(32'(DEB_CYCLES) - 32'd1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_v1;
    logic          r_v2;
    logic          r_armed;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    logic w_differs;
    logic w_flip;

    assign w_differs = (r_sync2 != r_level);
    assign w_flip    = w_differs && (r_cnt == C_LAST);
    assign o_press   = r_press;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_armed <= 1'b0;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            // r_v2 marks when r_sync2 holds a real key sample rather than
            // the reset-primed value; only a real released sample arms the
            // key, so a key held down through reset gives no event.
            r_v1    <= 1'b1;
            r_v2    <= r_v1;
            if (r_v2 && r_sync2) begin
                r_armed <= 1'b1;
            end
            r_press <= 1'b0;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_armed && !r_sync2;
            end else if (r_cnt != C_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/playback_ctrl.sv
// rtl/playback_ctrl.sv - play/pause/fast/next control FSM for the audio player
// Purpose : debounces three keys and runs the STOP/PLAY/PAUSE/SWITCH FSM.
// Ports   : Clk, Reset (async active-high)
//           key_play_n, key_fast_n, key_next_n - raw active-low keys
//           song_done  - end-of-song pulse from audio path
//           RW         - playing flag
//           Fast       - double-speed flag
//           SecondSong - song select
//           song_start - one-cycle restart pulse to audio path
module playback_ctrl
    import playback_pkg::*;
#(
    parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic key_play_n,
    input  logic key_fast_n,
    input  logic key_next_n,
    input  logic song_done,
    output logic RW,
    output logic Fast,
    output logic SecondSong,
    output logic song_start
);

    logic   w_play_ev;
    logic   w_fast_ev;
    logic   w_next_ev;

    state_t r_state;
    logic   r_rw;
    logic   r_fast;
    logic   r_second;
    logic   r_start;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_play (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_key_n (key_play_n),
        .o_press (w_play_ev)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fast (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_key_n (key_fast_n),
        .o_press (w_fast_ev)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_key_n (key_next_n),
        .o_press (w_next_ev)
    );

    assign RW         = r_rw;
    assign Fast       = r_fast;
    assign SecondSong = r_second;
    assign song_start = r_start;

    // Priority inside each state: next > song_done > play > fast. Losing
    // events are dropped because they are single-cycle pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_STOP;
            r_rw     <= 1'b0;
            r_fast   <= 1'b0;
            r_second <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_STOP: begin
                    if (w_next_ev) begin
                        r_state <= ST_SWITCH;
                        r_rw    <= 1'b0;
                    end else if (w_play_ev) begin
                        r_state <= ST_PLAY;
                        r_rw    <= 1'b1;
                        r_start <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_next_ev || song_done) begin
                        r_state <= ST_SWITCH;
                        r_rw    <= 1'b0;
                    end else if (w_play_ev) begin
                        r_state <= ST_PAUSE;
                        r_rw    <= 1'b0;
                    end else if (w_fast_ev) begin
                        r_fast <= ~r_fast;
                    end
                end
                ST_PAUSE: begin
                    if (w_next_ev) begin
                        r_state <= ST_SWITCH;
                    end else if (w_play_ev) begin
                        r_state <= ST_PLAY;
                        r_rw    <= 1'b1;
                    end
                end
                ST_SWITCH: begin
                    r_second <= ~r_second;
                    r_fast   <= 1'b0;
                    r_start  <= 1'b1;
                    r_state  <= ST_PLAY;
                    r_rw     <= 1'b1;
                end
                default: begin
                    r_state <= ST_STOP;
                    r_rw    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_playback_ctrl.sv
// tb/tb_playback_ctrl.sv - self-checking bench for playback_ctrl
`timescale 1ns/1ps
module tb_playback_ctrl;

    localparam logic [19:0] DEB  = 20'd4;
    localparam int          D    = 4;
    localparam int          MAXE = 8192;
    localparam int          S_STOP = 0, S_PLAY = 1, S_PAUSE = 2, S_SWITCH = 3;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic key_play_n = 1'b1;
    logic key_fast_n = 1'b1;
    logic key_next_n = 1'b1;
    logic song_done = 1'b0;
    logic RW, Fast, SecondSong, song_start;

    playback_ctrl #(.DEB_CYCLES(DEB)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .key_play_n (key_play_n),
        .key_fast_n (key_fast_n),
        .key_next_n (key_next_n),
        .song_done  (song_done),
        .RW         (RW),
        .Fast       (Fast),
        .SecondSong (SecondSong),
        .song_start (song_start)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int g_starts = 0;
    int g_rw_low = 0;

    // Reference model: a key registers when its last D synchronized samples
    // (raw delayed two cycles) all disagree with the debounced level; a press
    // counts only if a real released sample was seen before the press window.
    int m_k;
    int m_state;
    bit m_rw, m_fast, m_second, m_start;
    bit m_level[3];
    bit m_ev[3];
    int m_first_rel[3];
    bit m_raw[3][MAXE];

    always @(posedge Clk or posedge Reset) begin
        bit keys[3];
        bit ev_now[3];
        bit all_diff;
        bit s;
        if (Reset) begin
            m_k = 0; m_state = S_STOP;
            m_rw = 0; m_fast = 0; m_second = 0; m_start = 0;
            for (int i = 0; i < 3; i++) begin
                m_level[i] = 1'b1; m_ev[i] = 1'b0; m_first_rel[i] = 0;
            end
        end else begin
            keys[0] = key_play_n; keys[1] = key_fast_n; keys[2] = key_next_n;
            if (m_k < MAXE - 1) m_k = m_k + 1;
            m_start = 0;
            case (m_state)
                S_STOP:   if (m_ev[2]) m_state = S_SWITCH;
                          else if (m_ev[0]) begin m_state = S_PLAY; m_start = 1; end
                S_PLAY:   if (m_ev[2] || song_done) m_state = S_SWITCH;
                          else if (m_ev[0]) m_state = S_PAUSE;
                          else if (m_ev[1]) m_fast = !m_fast;
                S_PAUSE:  if (m_ev[2]) m_state = S_SWITCH;
                          else if (m_ev[0]) m_state = S_PLAY;
                default:  begin m_second = !m_second; m_fast = 0; m_start = 1; m_state = S_PLAY; end
            endcase
            m_rw = (m_state == S_PLAY);
            for (int i = 0; i < 3; i++) begin
                m_raw[i][m_k] = keys[i];
                if (keys[i] && m_first_rel[i] == 0) m_first_rel[i] = m_k;
                ev_now[i] = 1'b0;
                if (m_k >= D) begin
                    all_diff = 1'b1;
                    for (int j = m_k - D + 1; j <= m_k; j++) begin
                        s = (j >= 3) ? m_raw[i][j-2] : 1'b1;
                        if (s == m_level[i]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        m_level[i] = !m_level[i];
                        if (!m_level[i] && m_first_rel[i] != 0 && m_first_rel[i] <= m_k - 3)
                            ev_now[i] = 1'b1;
                    end
                end
            end
            for (int i = 0; i < 3; i++) m_ev[i] = ev_now[i];
        end
    end

    task automatic step();
        @(negedge Clk);
        if (song_start) g_starts++;
        if (!RW) g_rw_low++;
    endtask

    task automatic set_key(input int idx, input bit v);
        case (idx)
            0: key_play_n = v;
            1: key_fast_n = v;
            default: key_next_n = v;
        endcase
    endtask

    task automatic press(input int idx);
        set_key(idx, 1'b0);
        repeat (8) step();
        set_key(idx, 1'b1);
        repeat (8) step();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_checks++; if ({RW, Fast, SecondSong, song_start} !== 4'b0000) $display("FAIL reset_outputs: got %b expected 0000", {RW, Fast, SecondSong, song_start}); else n_pass++;
        Reset = 1'b0;
        repeat (6) step();
        n_checks++; if ({RW, Fast, SecondSong, song_start} !== 4'b0000) $display("FAIL idle_stop: got %b expected 0000", {RW, Fast, SecondSong, song_start}); else n_pass++;
    endtask

    task automatic test_play_start();
        g_starts = 0;
        set_key(0, 1'b0);
        repeat (10) step();
        set_key(0, 1'b1);
        repeat (8) step();
        n_checks++; if (g_starts !== 1) $display("FAIL play_start_pulses: got %0d expected 1", g_starts); else n_pass++;
        n_checks++; if (RW !== 1'b1) $display("FAIL play_rw: got %b expected 1", RW); else n_pass++;
        n_checks++; if (SecondSong !== 1'b0) $display("FAIL play_song: got %b expected 0", SecondSong); else n_pass++;
    endtask

    task automatic test_fast_pause();
        press(1);
        n_checks++; if (Fast !== 1'b1) $display("FAIL fast_toggle: got %b expected 1", Fast); else n_pass++;
        g_starts = 0;
        press(0);
        n_checks++; if ({RW, Fast} !== 2'b01) $display("FAIL pause_state: got RW,Fast=%b expected 01", {RW, Fast}); else n_pass++;
        press(0);
        n_checks++; if ({RW, Fast} !== 2'b11) $display("FAIL resume_state: got RW,Fast=%b expected 11", {RW, Fast}); else n_pass++;
        n_checks++; if (g_starts !== 0) $display("FAIL resume_no_start: got %0d expected 0", g_starts); else n_pass++;
    endtask

    task automatic test_pause_ignores();
        g_starts = 0;
        press(0);
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        repeat (3) step();
        n_checks++; if ({RW, SecondSong} !== 2'b00) $display("FAIL pause_song_done: got RW,SecondSong=%b expected 00", {RW, SecondSong}); else n_pass++;
        press(1);
        n_checks++; if (Fast !== 1'b1) $display("FAIL pause_fast_ignored: got %b expected 1", Fast); else n_pass++;
        press(0);
        n_checks++; if ({RW, g_starts} !== {1'b1, 32'd0}) $display("FAIL pause_resume: got RW=%b starts=%0d expected RW=1 starts=0", RW, g_starts); else n_pass++;
    endtask

    task automatic test_song_done();
        press(2);
        n_checks++; if ({RW, Fast, SecondSong} !== 3'b101) $display("FAIL next_switch: got %b expected 101", {RW, Fast, SecondSong}); else n_pass++;
        press(1);
        n_checks++; if (Fast !== 1'b1) $display("FAIL fast_before_done: got %b expected 1", Fast); else n_pass++;
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        n_checks++; if ({RW, song_start} !== 2'b00) $display("FAIL done_switch_cycle: got %b expected 00", {RW, song_start}); else n_pass++;
        step();
        n_checks++; if ({RW, Fast, SecondSong, song_start} !== 4'b1001) $display("FAIL done_result: got %b expected 1001", {RW, Fast, SecondSong, song_start}); else n_pass++;
        step();
        n_checks++; if ({RW, song_start} !== 2'b10) $display("FAIL done_pulse_width: got %b expected 10", {RW, song_start}); else n_pass++;
    endtask

    task automatic test_glitch();
        g_starts = 0;
        set_key(2, 1'b0);
        repeat (3) step();
        set_key(2, 1'b1);
        repeat (12) step();
        n_checks++; if ({SecondSong, g_starts} !== {1'b0, 32'd0}) $display("FAIL glitch_3: got SecondSong=%b starts=%0d expected 0 0", SecondSong, g_starts); else n_pass++;
        set_key(2, 1'b0);
        repeat (4) step();
        set_key(2, 1'b1);
        repeat (12) step();
        n_checks++; if ({SecondSong, g_starts} !== {1'b1, 32'd1}) $display("FAIL press_4: got SecondSong=%b starts=%0d expected 1 1", SecondSong, g_starts); else n_pass++;
    endtask

    task automatic test_simultaneous();
        g_starts = 0;
        g_rw_low = 0;
        key_play_n = 1'b0;
        key_next_n = 1'b0;
        repeat (10) step();
        key_play_n = 1'b1;
        key_next_n = 1'b1;
        repeat (10) step();
        n_checks++; if (g_starts !== 1) $display("FAIL simul_starts: got %0d expected 1", g_starts); else n_pass++;
        n_checks++; if (g_rw_low !== 1) $display("FAIL simul_rw_low_cycles: got %0d expected 1", g_rw_low); else n_pass++;
        n_checks++; if ({RW, SecondSong} !== 2'b10) $display("FAIL simul_end: got RW,SecondSong=%b expected 10", {RW, SecondSong}); else n_pass++;
    endtask

    task automatic test_reset_mid_press();
        set_key(0, 1'b0);
        repeat (2) step();
        #2 Reset = 1'b1;
        #1;
        n_checks++; if ({RW, Fast, SecondSong, song_start} !== 4'b0000) $display("FAIL async_reset: got %b expected 0000", {RW, Fast, SecondSong, song_start}); else n_pass++;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        g_starts = 0;
        repeat (20) step();
        n_checks++; if ({RW, g_starts} !== {1'b0, 32'd0}) $display("FAIL held_through_reset: got RW=%b starts=%0d expected 0 0", RW, g_starts); else n_pass++;
        set_key(0, 1'b1);
        repeat (10) step();
        set_key(0, 1'b0);
        repeat (10) step();
        set_key(0, 1'b1);
        repeat (8) step();
        n_checks++; if ({RW, g_starts} !== {1'b1, 32'd1}) $display("FAIL repress_after_reset: got RW=%b starts=%0d expected 1 1", RW, g_starts); else n_pass++;
    endtask

    task automatic test_random();
        bit cur[3];
        int dur[3];
        for (int i = 0; i < 3; i++) begin
            cur[i] = 1'b1;
            dur[i] = $urandom_range(1, 12);
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            n_checks++; if (RW !== m_rw) $display("FAIL rand_rw cyc %0d: got %b expected %b", c, RW, m_rw); else n_pass++;
            n_checks++; if (Fast !== m_fast) $display("FAIL rand_fast cyc %0d: got %b expected %b", c, Fast, m_fast); else n_pass++;
            n_checks++; if (SecondSong !== m_second) $display("FAIL rand_song cyc %0d: got %b expected %b", c, SecondSong, m_second); else n_pass++;
            n_checks++; if (song_start !== m_start) $display("FAIL rand_start cyc %0d: got %b expected %b", c, song_start, m_start); else n_pass++;
            song_done = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 3; i++) begin
                if (dur[i] == 0) begin
                    cur[i] = ~cur[i];
                    dur[i] = $urandom_range(1, 12);
                end
                dur[i]--;
            end
            key_play_n = cur[0];
            key_fast_n = cur[1];
            key_next_n = cur[2];
            if (c == 1500) begin
                #2 Reset = 1'b1;
                #4 Reset = 1'b0;
            end
        end
        song_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_play_start();
        test_fast_pause();
        test_pause_ignores();
        test_song_done();
        test_glitch();
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
